// File: rtl/pixel_window_gen_if.sv
// Pixel stream in / sliding window out bundle for pixel_window_gen.
interface pixel_window_gen_if #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHANNELS        = 1,
    parameter int unsigned KERNEL_SIZE     = 5,
    parameter int unsigned MAX_IMAGE_WIDTH = 4096
);
    localparam int unsigned WW = $clog2(MAX_IMAGE_WIDTH + 1);
    localparam int unsigned PW = CHANNELS * DATA_WIDTH;
    localparam int unsigned OW = PW * KERNEL_SIZE * KERNEL_SIZE;

    logic [WW-1:0] i_image_width;
    logic [PW-1:0] i_data;
    logic          i_data_valid;
    logic          i_start_of_frame;
    logic [OW-1:0] o_window;
    logic          o_data_valid;
    logic          o_start_of_frame;
    logic          o_end_of_line;

    modport master (
        output i_image_width, i_data, i_data_valid, i_start_of_frame,
        input  o_window, o_data_valid, o_start_of_frame, o_end_of_line
    );

    modport slave (
        input  i_image_width, i_data, i_data_valid, i_start_of_frame,
        output o_window, o_data_valid, o_start_of_frame, o_end_of_line
    );
endinterface

// File: rtl/pixel_window_gen.sv
// KERNEL_SIZE x KERNEL_SIZE sliding window generator over a multi-channel raster
// stream; emits only fully populated windows, flags first window and end of line.
module pixel_window_gen #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHANNELS        = 1,
    parameter int unsigned KERNEL_SIZE     = 5,
    parameter int unsigned MAX_IMAGE_WIDTH = 4096
) (
    input  logic               i_clk,
    input  logic               i_reset,
    pixel_window_gen_if.slave  bus
);
    localparam int unsigned K   = KERNEL_SIZE;
    localparam int unsigned KM1 = K - 1;
    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned CH  = CHANNELS;
    localparam int unsigned PW  = CH * DW;
    localparam int unsigned OW  = CH * K * K * DW;
    localparam int unsigned WW  = $clog2(MAX_IMAGE_WIDTH + 1);
    localparam int unsigned CW  = (MAX_IMAGE_WIDTH > 1) ? $clog2(MAX_IMAGE_WIDTH) : 1;
    localparam int unsigned RW  = $clog2(K);

    // Line buffers: r_line_buf[0] holds the oldest row, [KM1-1] the previous row.
    logic [PW-1:0] r_line_buf [KM1][MAX_IMAGE_WIDTH];
    // The KM1 most recent columns, indexed [column][row].
    logic [PW-1:0] r_hist [KM1][K];

    logic [WW-1:0] r_col;
    logic [WW-1:0] r_width;
    logic [RW-1:0] r_row;
    logic          r_frame_active;
    logic          r_sof_pending;
    logic [OW-1:0] r_window;
    logic          r_valid;
    logic          r_sof;
    logic          r_eol;

    logic          w_sof;
    logic          w_accept;
    logic [WW-1:0] w_width_in;
    logic [WW-1:0] w_width;
    logic [WW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_addr;
    logic          w_last_col;
    logic          w_wrap;
    logic          w_emit;
    logic [PW-1:0] w_col_vec [K];
    logic [PW-1:0] w_win [K][K];
    logic [OW-1:0] w_window;

    // Position of the current pixel; a SOF pixel is always (0,0) with the fresh width.
    always_comb begin
        w_sof      = bus.i_data_valid & bus.i_start_of_frame;
        w_accept   = bus.i_data_valid & (r_frame_active | bus.i_start_of_frame);
        w_width_in = (bus.i_image_width > WW'(MAX_IMAGE_WIDTH)) ? WW'(MAX_IMAGE_WIDTH)
                                                                 : bus.i_image_width;
        w_width    = w_sof ? w_width_in : r_width;
        w_col      = w_sof ? '0 : r_col;
        w_row      = w_sof ? '0 : r_row;
        w_addr     = CW'(w_col);
        // Width 0 gives all-ones here and never matches; the MAX guard keeps col in range.
        w_last_col = (w_col == (w_width - WW'(1)));
        w_wrap     = w_last_col | (w_col == WW'(MAX_IMAGE_WIDTH - 1));
        w_emit     = (w_row == RW'(KM1)) && (w_col >= WW'(KM1)) && (w_width >= WW'(K));
    end

    // Newest column: buffered rows above, live pixel at the bottom.
    always_comb begin
        w_col_vec[KM1] = bus.i_data;
        for (int unsigned r = 0; r < KM1; r++) begin
            w_col_vec[r] = r_line_buf[r][w_addr];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < KM1; k++) begin
            for (int unsigned r = 0; r < K; r++) begin
                w_win[k][r] = r_hist[k][r];
            end
        end
        for (int unsigned r = 0; r < K; r++) begin
            w_win[KM1][r] = w_col_vec[r];
        end
    end

    // Flatten to the (channel, row, column) output layout.
    always_comb begin
        w_window = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned k = 0; k < K; k++) begin
                    w_window[((c * K + r) * K + k) * DW +: DW] = w_win[k][r][c * DW +: DW];
                end
            end
        end
    end

    // Storage without reset: stale contents are masked by the emit gating.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int unsigned j = 0; j < KM1; j++) begin
                r_line_buf[j][w_addr] <= w_col_vec[j + 1];
            end
            for (int unsigned k = 0; k < KM1; k++) begin
                for (int unsigned r = 0; r < K; r++) begin
                    r_hist[k][r] <= w_win[k + 1][r];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col          <= '0;
            r_row          <= '0;
            r_width        <= '0;
            r_frame_active <= 1'b0;
            r_sof_pending  <= 1'b0;
            r_window       <= '0;
            r_valid        <= 1'b0;
            r_sof          <= 1'b0;
            r_eol          <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            if (w_accept) begin
                r_frame_active <= 1'b1;
                r_width        <= w_width;
                if (w_wrap) begin
                    r_col <= '0;
                    r_row <= (w_row == RW'(KM1)) ? w_row : w_row + RW'(1);
                end else begin
                    r_col <= w_col + WW'(1);
                    r_row <= w_row;
                end
                if (w_emit) begin
                    r_window      <= w_window;
                    r_valid       <= 1'b1;
                    r_sof         <= w_sof | r_sof_pending;
                    r_eol         <= w_last_col;
                    r_sof_pending <= 1'b0;
                end else begin
                    r_sof_pending <= w_sof | r_sof_pending;
                end
            end
        end
    end

    assign bus.o_window         = r_window;
    assign bus.o_data_valid     = r_valid;
    assign bus.o_start_of_frame = r_sof;
    assign bus.o_end_of_line    = r_eol;
endmodule
